// File: rtl/fifo_flex.sv
// fifo_flex: single-clock synchronous FIFO for any DEPTH >= 2.
// Provides registered-read or first-word-fall-through output, almost-full and
// almost-empty thresholds, an occupancy count, a synchronous flush, and sticky
// overflow/underflow error flags.
module fifo_flex #(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 8,
    parameter int FWFT      = 0,
    parameter int AFULL_TH  = 6,
    parameter int AEMPTY_TH = 2,
    localparam int W_CNT    = $clog2(DEPTH + 1),
    localparam int W_POS    = ($clog2(DEPTH) > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clr,
    input  logic             i_enq,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_deq,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_dvalid,
    output logic             o_empty,
    output logic             o_full,
    output logic             o_afull,
    output logic             o_aempty,
    output logic [W_CNT-1:0] o_count,
    output logic             o_ovf,
    output logic             o_udf
);

    logic [WIDTH-1:0] r_mem [0:DEPTH-1];
    logic [W_POS-1:0] r_head;
    logic [W_POS-1:0] r_tail;
    logic [W_CNT-1:0] r_count;
    logic             r_ovf;
    logic             r_udf;

    logic             w_do_deq;
    logic             w_do_enq;
    logic [W_POS-1:0] w_head_nxt;
    logic [W_POS-1:0] w_tail_nxt;

    // Accept decisions use the flags as they stand before the edge; a full
    // FIFO still takes a write when a read frees a slot in the same cycle,
    // but an empty FIFO never bypasses a write straight to the reader.
    assign w_do_deq = i_deq & ~o_empty;
    assign w_do_enq = i_enq & (~o_full | w_do_deq);

    // Explicit wrap compare so DEPTH need not be a power of two.
    assign w_head_nxt = (r_head == W_POS'(DEPTH - 1)) ? '0 : r_head + 1'b1;
    assign w_tail_nxt = (r_tail == W_POS'(DEPTH - 1)) ? '0 : r_tail + 1'b1;

    // All status flags derive from the registered occupancy only.
    assign o_empty  = (r_count == '0);
    assign o_full   = (r_count == W_CNT'(DEPTH));
    assign o_afull  = (r_count >= W_CNT'(AFULL_TH));
    assign o_aempty = (r_count <= W_CNT'(AEMPTY_TH));
    assign o_count  = r_count;
    assign o_ovf    = r_ovf;
    assign o_udf    = r_udf;

    // Storage array; not reset, and a flush blocks the write.
    always_ff @(posedge i_clk) begin
        if (!i_clr && w_do_enq)
            r_mem[r_tail] <= i_din;
    end

    // Pointers, occupancy and sticky error flags; flush outranks ENQ/DEQ.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_udf   <= 1'b0;
        end else if (i_clr) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_udf   <= 1'b0;
        end else begin
            if (w_do_deq) r_head <= w_head_nxt;
            if (w_do_enq) r_tail <= w_tail_nxt;
            if (w_do_enq && !w_do_deq)
                r_count <= r_count + 1'b1;
            else if (w_do_deq && !w_do_enq)
                r_count <= r_count - 1'b1;
            if (i_enq && !w_do_enq) r_ovf <= 1'b1;
            if (i_deq && !w_do_deq) r_udf <= 1'b1;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head word is always presented; a pop reveals the next word.
            assign o_dout   = r_mem[r_head];
            assign o_dvalid = ~o_empty;
        end else begin : g_reg
            logic [WIDTH-1:0] r_dout;
            logic             r_dvalid;

            // Registered read: word lands one cycle after the accepted DEQ,
            // and DOUT holds its value between reads.
            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    r_dout   <= '0;
                    r_dvalid <= 1'b0;
                end else if (i_clr) begin
                    r_dout   <= '0;
                    r_dvalid <= 1'b0;
                end else begin
                    r_dvalid <= w_do_deq;
                    if (w_do_deq)
                        r_dout <= r_mem[r_head];
                end
            end

            assign o_dout   = r_dout;
            assign o_dvalid = r_dvalid;
        end
    endgenerate

endmodule

// File: tb/tb_fifo_flex.sv
// tb_fifo_flex: drives a registered-read and an FWFT instance with identical
// stimulus and checks both against a queue-based reference FIFO.
module tb_fifo_flex;

    localparam int W = 8;
    localparam int D = 5;
    localparam int AF = 4;
    localparam int AE = 1;
    localparam int WC = $clog2(D + 1);

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         clr = 1'b0;
    logic         enq = 1'b0;
    logic         deq = 1'b0;
    logic [W-1:0] din = '0;

    logic [W-1:0]  dout0, dout1;
    logic          dvalid0, dvalid1, empty0, empty1, full0, full1;
    logic          afull0, afull1, aempty0, aempty1;
    logic          ovf0, ovf1, udf0, udf1;
    logic [WC-1:0] count0, count1;

    always #5 clk = ~clk;

    fifo_flex #(.WIDTH(W), .DEPTH(D), .FWFT(0), .AFULL_TH(AF), .AEMPTY_TH(AE)) u0 (
        .i_clk(clk), .i_rst(rst), .i_clr(clr), .i_enq(enq), .i_din(din), .i_deq(deq),
        .o_dout(dout0), .o_dvalid(dvalid0), .o_empty(empty0), .o_full(full0),
        .o_afull(afull0), .o_aempty(aempty0), .o_count(count0), .o_ovf(ovf0), .o_udf(udf0));

    fifo_flex #(.WIDTH(W), .DEPTH(D), .FWFT(1), .AFULL_TH(AF), .AEMPTY_TH(AE)) u1 (
        .i_clk(clk), .i_rst(rst), .i_clr(clr), .i_enq(enq), .i_din(din), .i_deq(deq),
        .o_dout(dout1), .o_dvalid(dvalid1), .o_empty(empty1), .o_full(full1),
        .o_afull(afull1), .o_aempty(aempty1), .o_count(count1), .o_ovf(ovf1), .o_udf(udf1));

    // Reference FIFO contents, expected read-data scoreboard, and model state.
    logic [W-1:0] mq[$];
    logic [W-1:0] sbq[$];
    logic         m_ovf = 1'b0, m_udf = 1'b0, m_dv = 1'b0;
    logic [W-1:0] m_last = '0;

    typedef struct {
        string name;
        int    sel;
        int    exp;
    } exp_t;
    exp_t dq[$];

    int checks = 0;
    int failures = 0;

    // Reference model: a plain queue following the accept rules.
    always @(posedge clk or posedge rst) begin
        if (rst || clr) begin
            mq.delete();
            sbq.delete();
            m_ovf  <= 1'b0;
            m_udf  <= 1'b0;
            m_dv   <= 1'b0;
            m_last <= '0;
        end else begin
            automatic bit d = deq && (mq.size() != 0);
            automatic bit e = enq && ((mq.size() < D) || d);
            automatic logic [W-1:0] w;
            m_dv <= d;
            if (d) begin
                w = mq.pop_front();
                sbq.push_back(w);
                m_last <= w;
            end
            if (e) mq.push_back(din);
            if (enq && !e) m_ovf <= 1'b1;
            if (deq && !d) m_udf <= 1'b1;
        end
    end

    function automatic int getsig(input int sel);
        case (sel)
            0: return int'(count0);
            1: return int'(full0);
            2: return int'(ovf0);
            3: return int'(udf0);
            4: return int'(dvalid0);
            5: return int'(dout0);
            6: return int'(empty0);
            7: return int'(afull0);
            8: return int'(dvalid1);
            9: return int'(dout1);
            10: return int'(empty1);
            11: return int'(aempty0);
            default: return -1;
        endcase
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compares every output against the model away from the clock edge.
    always @(negedge clk) begin
        automatic int n = mq.size();
        chk("count0", int'(count0), n);
        chk("count1", int'(count1), n);
        chk("empty0", int'(empty0), int'(n == 0));
        chk("empty1", int'(empty1), int'(n == 0));
        chk("full0", int'(full0), int'(n == D));
        chk("full1", int'(full1), int'(n == D));
        chk("afull0", int'(afull0), int'(n >= AF));
        chk("afull1", int'(afull1), int'(n >= AF));
        chk("aempty0", int'(aempty0), int'(n <= AE));
        chk("aempty1", int'(aempty1), int'(n <= AE));
        chk("ovf0", int'(ovf0), int'(m_ovf));
        chk("ovf1", int'(ovf1), int'(m_ovf));
        chk("udf0", int'(udf0), int'(m_udf));
        chk("udf1", int'(udf1), int'(m_udf));
        chk("dvalid0", int'(dvalid0), int'(m_dv));
        if (dvalid0) begin
            if (sbq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_dout0: dvalid with dout %0h but no read expected", dout0);
            end else begin
                chk("sb_dout0", int'(dout0), int'(sbq.pop_front()));
            end
        end else begin
            chk("dout0_hold", int'(dout0), int'(m_last));
        end
        chk("dvalid1", int'(dvalid1), int'(n != 0));
        if (n != 0) chk("dout1_head", int'(dout1), int'(mq[0]));
        while (dq.size() > 0) begin
            automatic exp_t x = dq.pop_front();
            chk(x.name, getsig(x.sel), x.exp);
        end
    end

    // Inputs change 1 time unit after the rising edge.
    task automatic step(input logic e, input logic [W-1:0] d, input logic q, input logic c);
        @(posedge clk);
        #1;
        enq = e; din = d; deq = q; clr = c;
    endtask

    task automatic idle();
        step(1'b0, '0, 1'b0, 1'b0);
    endtask

    // Directed expectation checked at the next falling edge.
    task automatic expect_at(input string name, input int sel, input int exp);
        exp_t x;
        x.name = name; x.sel = sel; x.exp = exp;
        dq.push_back(x);
    endtask

    initial begin
        #1 rst = 1'b1;
        expect_at("rst_count", 0, 0);
        expect_at("rst_empty", 6, 1);
        expect_at("rst_dvalid", 4, 0);
        expect_at("rst_dout", 5, 0);
        @(posedge clk); #1 rst = 1'b0;

        // Fill a non-power-of-two FIFO, overflow it, then drain in order.
        for (int i = 1; i <= 5; i++) step(1'b1, W'(i), 1'b0, 1'b0);
        step(1'b1, 8'h06, 1'b0, 1'b0);
        idle();
        expect_at("t1_count", 0, 5);
        expect_at("t1_full", 1, 1);
        expect_at("t1_ovf", 2, 1);
        for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b1, 1'b0);
        idle();
        expect_at("t1_dvalid", 4, 1);
        expect_at("t1_dout5", 5, 5);
        idle();
        expect_at("t1_empty", 6, 1);
        step(1'b0, '0, 1'b0, 1'b1);
        idle();
        expect_at("t1_clr_ovf", 2, 0);

        // Full plus simultaneous ENQ/DEQ: both accepted.
        for (int i = 0; i < 5; i++) step(1'b1, W'(8'h10 + i), 1'b0, 1'b0);
        step(1'b1, 8'hAA, 1'b1, 1'b0);
        idle();
        expect_at("t3_count", 0, 5);
        expect_at("t3_ovf", 2, 0);
        for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b1, 1'b0);
        idle();
        expect_at("t3_dout_aa", 5, 8'hAA);

        // Empty plus simultaneous ENQ/DEQ: write taken, read refused.
        step(1'b1, 8'h11, 1'b1, 1'b0);
        idle();
        expect_at("t4_count", 0, 1);
        expect_at("t4_udf", 3, 1);
        expect_at("t4_dvalid", 4, 0);
        step(1'b0, '0, 1'b1, 1'b0);
        idle();
        expect_at("t4_dout", 5, 8'h11);

        // Pointer wrap: 4 rounds of 3 in, 3 out.
        step(1'b0, '0, 1'b0, 1'b1);
        for (int r = 0; r < 4; r++) begin
            for (int j = 0; j < 3; j++) step(1'b1, W'(r * 16 + j + 1), 1'b0, 1'b0);
            for (int j = 0; j < 3; j++) step(1'b0, '0, 1'b1, 1'b0);
        end
        idle();
        expect_at("t2_count", 0, 0);

        // FWFT: word appears without a DEQ.
        step(1'b1, 8'h07, 1'b0, 1'b0);
        idle();
        expect_at("t5_dvalid1", 8, 1);
        expect_at("t5_dout1", 9, 7);
        step(1'b0, '0, 1'b1, 1'b0);
        idle();
        expect_at("t5_empty1", 10, 1);

        // Thresholds, flush mid-stream, async reset between edges.
        for (int i = 0; i < 4; i++) step(1'b1, W'(8'h40 + i), 1'b0, 1'b0);
        idle();
        expect_at("t6_afull", 7, 1);
        expect_at("t6_aempty", 11, 0);
        step(1'b1, 8'h44, 1'b0, 1'b0);
        step(1'b1, 8'h45, 1'b0, 1'b0);
        step(1'b1, 8'h46, 1'b1, 1'b1);
        idle();
        expect_at("t6_clr_count", 0, 0);
        expect_at("t6_clr_empty", 6, 1);
        expect_at("t6_clr_ovf", 2, 0);
        expect_at("t6_clr_udf", 3, 0);
        step(1'b1, 8'h50, 1'b0, 1'b0);
        step(1'b1, 8'h51, 1'b0, 1'b0);
        @(posedge clk); #1;
        enq = 1'b0; rst = 1'b1;
        expect_at("t6_arst_count", 0, 0);
        expect_at("t6_arst_empty", 6, 1);
        expect_at("t6_arst_aempty", 11, 1);
        @(posedge clk); #1 rst = 1'b0;

        // Randomized traffic in fill-biased, drain-biased and balanced phases.
        for (int i = 0; i < 1500; i++) begin
            automatic int pe = (i < 500) ? 75 : (i < 1000) ? 30 : 50;
            automatic int pd = (i < 500) ? 30 : (i < 1000) ? 75 : 50;
            step(($urandom_range(0, 99) < pe), W'($urandom), ($urandom_range(0, 99) < pd),
                 ($urandom_range(0, 199) == 0));
        end
        idle();
        repeat (3) @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
